// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: FSM states, opcode
// constants shared with the control unit, and default widths.
package fetch_unit_pkg;

    localparam int IW_DEF    = 18;
    localparam int AW_DEF    = 10;
    localparam int OFS_W_DEF = 10;

    // Opcode constants, kept in step with the control unit's opcode list
    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_CMP  = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_flag_reg.sv
// ZF/CF status register: loads both flags together when we=1, clears on
// asynchronous active-low reset.
module flag_reg (
    input  logic clk,
    input  logic rst_n,
    input  logic we,
    input  logic zf_d,
    input  logic cf_d,
    output logic zf,
    output logic cf
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf <= 1'b0;
            cf <= 1'b0;
        end else if (we) begin
            zf <= zf_d;
            cf <= cf_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, instruction register, flags and the
// IDLE/FETCH/EXEC(/HALT) sequencer. Define FETCH_UNIT_HALT_EN to make opcode 0000 halt.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int IW    = IW_DEF,
    parameter int AW    = AW_DEF,
    parameter int OFS_W = OFS_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    input  logic          imem_valid,
    output logic [IW-1:0] instr,
    output logic [3:0]    opcode,
    output logic          instr_valid,
    output logic          ZF,
    output logic          CF,
    input  logic          alu_zf,
    input  logic          alu_cf,
    input  logic          mem_busy,
    input  logic          pc_write,
    input  logic          branch,
    output logic [AW-1:0] pc,
    output logic          halted,
    output fetch_state_e  dbg_state
);

    // Instruction memory handshake: imem_req stays high with imem_addr held at
    // pc until the first cycle imem_valid=1, which completes the transfer;
    // imem_valid in any other cycle carries no meaning and is ignored.

    fetch_state_e         state;
    logic                 exec_done;
    logic                 flag_we;
    logic signed [OFS_W-1:0] ofs_field;
    logic [AW-1:0]        ofs_ext;
    logic [AW-1:0]        pc_inc;
    logic [AW-1:0]        pc_next;
    logic                 unused_branch;

    // Branch-taken status is informational; pc_write alone selects the target
    assign unused_branch = branch;

    assign opcode    = instr[IW-1:IW-4];
    assign imem_addr = pc;
    assign dbg_state = state;

    assign ofs_field = instr[OFS_W-1:0];
    assign ofs_ext   = AW'(ofs_field);
    assign pc_inc    = pc + AW'(1);
    assign pc_next   = pc_write ? (pc_inc + ofs_ext) : pc_inc;

    assign exec_done = (state == ST_EXEC) && !mem_busy;
    assign flag_we   = exec_done && (opcode == OP_CMP);

    flag_reg u_flag_reg (
        .clk   (clk),
        .rst_n (reset),
        .we    (flag_we),
        .zf_d  (alu_zf),
        .cf_d  (alu_cf),
        .zf    (ZF),
        .cf    (CF)
    );

`ifdef FETCH_UNIT_HALT_EN
    logic halted_q;
    logic halt_op;

    assign halt_op = (opcode == OP_HALT);
    assign halted  = halted_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            pc          <= '0;
            instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_valid) begin
                        instr       <= imem_rdata;
                        state       <= ST_EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (!mem_busy) begin
                        instr_valid <= 1'b0;
                        // A halting instruction leaves pc pointing at itself
                        if (halt_op) begin
                            state    <= ST_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            pc       <= pc_next;
                            state    <= ST_FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state       <= ST_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end
`else
    assign halted = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            pc          <= '0;
            instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_valid) begin
                        instr       <= imem_rdata;
                        state       <= ST_EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (!mem_busy) begin
                        pc          <= pc_next;
                        state       <= ST_FETCH;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-side front end that produces the opcode and flag inputs consumed by the control unit, and acts on its returned pc_write/branch decisions.
- Owns the PC, the 18-bit instruction register and the ZF/CF flag register.
- Fetches from instruction memory over a req/valid handshake.
- Holds each instruction stable for the control unit until execution completes.

Parameters:
IW, 18, instruction width (opcode at [IW-1:IW-4])
AW, 10, PC / instruction address width
OFS_W, 10, signed branch offset field width, instr[OFS_W-1:0]

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  leave IDLE and begin fetching
imem_req  output  1  fetch request
imem_addr  output  AW  fetch address, equals pc
imem_rdata  input  IW  fetched instruction
imem_valid  input  1  imem_rdata valid this cycle
instr  output  IW  instruction register
opcode  output  4  instr[IW-1:IW-4], to control unit
instr_valid  output  1  instr held for execution
ZF  output  1  zero flag register
CF  output  1  carry flag register
alu_zf  input  1  ALU zero result
alu_cf  input  1  ALU carry result
mem_busy  input  1  data-memory operation still in progress
pc_write  input  1  from control unit: take jump/branch
branch  input  1  from control unit: conditional branch taken (status only)
pc  output  AW  program counter
halted  output  1  HALT reached (tied 0 without macro)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pc=0, instr=0, ZF=0, CF=0, imem_req=0, instr_valid=0, halted=0.
- States: IDLE, FETCH, EXEC, HALT (HALT only with the macro).
- IDLE: all outputs idle. start=1 moves to FETCH on the next edge. start is ignored in every other state.
- FETCH:
  - imem_req=1; imem_addr=pc, stable while waiting.
  - On a cycle with imem_valid=1: instr<=imem_rdata and the state moves to EXEC.
  - Zero-wait allowed: valid in the first FETCH cycle gives a 1-cycle fetch.
  - imem_valid outside FETCH is ignored.
- EXEC:
  - instr_valid=1, imem_req=0.
  - While mem_busy=1: hold; pc, instr and flags are unchanged.
  - On the first EXEC cycle with mem_busy=0, all of the following happen and the state returns to FETCH:
    - If opcode==4'b1010 (CMP): ZF<=alu_zf, CF<=alu_cf. Flags are otherwise never written.
    - PC update: if pc_write=1, pc <= pc + 1 + sext(instr[OFS_W-1:0]); else pc <= pc + 1.
- Arithmetic is modulo 2^AW; PC wraps silently (1023+1 -> 0).
- Flags written by a CMP are visible to the next instruction's EXEC (a CMP/JE pair works back-to-back).
- branch input is not used for control; pc_write alone selects the target.
- Minimum throughput: 2 cycles per instruction (zero-wait fetch, no mem_busy).
- Reset mid-FETCH or mid-EXEC: immediate return to IDLE with reset values; an in-flight imem_valid is discarded.

Optional Feature:
Macro FETCH_UNIT_HALT_EN.
- Defined: opcode 4'b0000 completing EXEC moves to HALT.
  - In HALT: halted=1, imem_req=0, instr_valid=0, pc stays at the HALT address.
  - HALT is left only by reset.
- Undefined: opcode 0000 is a NOP (pc+1), the HALT state does not exist, halted is tied 0.

Decomposition:
- Shared package: state enum (IDLE/FETCH/EXEC/HALT), OP_CMP=4'b1010, OP_HALT=4'b0000, IW/AW/OFS_W defaults.
- The opcode constants are shared with the control unit's opcode list.
- One natural sub-module: flag_reg (ZF/CF register with write enable and async active-low reset).
- PC adder and FSM stay in fetch_unit.

Test Plan:
- Reset, start=1, memory returns valid in the same cycle -> imem_addr 0,1,2 on successive fetches, one instruction every 2 cycles, instr_valid alternates.
- imem_valid delayed 3 cycles at pc=4 -> imem_req high 3 cycles with imem_addr=4 stable, then instr latched and EXEC entered.
- pc=5, instr[9:0]=10'h3FD (-3), pc_write=1 -> pc=3. Same instruction with pc_write=0 -> pc=6.
- CMP (opcode 1010) with alu_zf=1, alu_cf=0 -> ZF=1, CF=0 after EXEC. A following ADD with alu_zf=0 -> ZF stays 1. Non-taken wrap: pc=1023 -> pc=0.
- mem_busy=1 for 2 cycles in EXEC -> EXEC lasts 3 cycles, pc/flags unchanged until mem_busy=0. Reset asserted during FETCH -> all outputs at reset values within the same cycle.
- FETCH_UNIT_HALT_EN defined, opcode 0000 at pc=7 -> halted=1, pc=7, no further imem_req. Undefined -> pc=8, fetch continues.
